// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared types and redirect ranking for the IF-stage PC generator
//
// Contents:
//   pc_state_e : fetch FSM states (BOOT, RUN, PEND)
//   pc_src_e   : next-PC source tags, lowest to highest select priority
//   src_rank   : rank used to decide whether a new redirect may overwrite the pending slot
package pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } pc_state_e;

    typedef enum logic [2:0] {
        SRC_SEQ  = 3'd0,
        SRC_ID   = 3'd1,
        SRC_PEND = 3'd2,
        SRC_EX   = 3'd3,
        SRC_TRAP = 3'd4
    } pc_src_e;

    // Only ID/EX/TRAP ever sit in the pending slot. SRC_PEND never gets a rank of
    // its own because the slot remembers the original source of its redirect.
    function automatic logic [1:0] src_rank(input pc_src_e src);
        logic [1:0] rank;
        case (src)
            SRC_TRAP: rank = 2'd3;
            SRC_EX:   rank = 2'd2;
            SRC_ID:   rank = 2'd1;
            default:  rank = 2'd0;
        endcase
        return rank;
    endfunction

endpackage

// File: rtl/pc_gen_unit_if.sv
// rtl/pc_gen_unit_if.sv - instruction-memory fetch request bus driven by the PC generator
//
// Signals:
//   imem_req_valid : fetch request valid (PC generator -> imem)
//   imem_req_ready : imem accepts the request (imem -> PC generator)
//   pc_if          : current fetch PC
//   pc_plus_if     : pc_if + ILEN_B, for link-address computation downstream
// Modports: master = PC generator side, slave = instruction memory side.
interface pc_gen_unit_if #(
    parameter int XLEN = 64
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] pc_if;
    logic [XLEN-1:0] pc_plus_if;

    modport master (
        output imem_req_valid,
        output pc_if,
        output pc_plus_if,
        input  imem_req_ready
    );

    modport slave (
        input  imem_req_valid,
        input  pc_if,
        input  pc_plus_if,
        output imem_req_ready
    );
endinterface

// File: rtl/pc_redirect_arb.sv
// rtl/pc_redirect_arb.sv - combinational next-PC source priority select
//
// Ports:
//   trap_valid/trap_target : CSR trap/xret redirect (tied off by the top when traps are disabled)
//   ex_valid/ex_target     : EX-stage redirect
//   pend_valid/pend_src/pend_target : latched redirect waiting for fetch to advance
//   id_valid/id_target     : ID-stage early jump
//   seq_target             : pc_if + ILEN_B
//   sel_src/sel_target     : winning source and raw (unaligned) target if fetch advances now
//   new_valid/new_src/new_target : highest-priority redirect arriving this cycle
//   new_ge_pend            : the arriving redirect may be written into the pending slot
module pc_redirect_arb
    import pc_gen_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_target,
    input  logic            pend_valid,
    input  pc_src_e         pend_src,
    input  logic [XLEN-1:0] pend_target,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_target,
    input  logic [XLEN-1:0] seq_target,
    output pc_src_e         sel_src,
    output logic [XLEN-1:0] sel_target,
    output logic            new_valid,
    output pc_src_e         new_src,
    output logic [XLEN-1:0] new_target,
    output logic            new_ge_pend
);

    // Select used when fetch advances: trap > ex > pending > id > sequential.
    always_comb begin
        sel_src    = SRC_SEQ;
        sel_target = seq_target;
        if (trap_valid) begin
            sel_src    = SRC_TRAP;
            sel_target = trap_target;
        end else if (ex_valid) begin
            sel_src    = SRC_EX;
            sel_target = ex_target;
        end else if (pend_valid) begin
            sel_src    = SRC_PEND;
            sel_target = pend_target;
        end else if (id_valid) begin
            sel_src    = SRC_ID;
            sel_target = id_target;
        end
    end

    // Best of the redirects arriving this cycle, ignoring the slot itself.
    always_comb begin
        new_src    = SRC_SEQ;
        new_target = id_target;
        if (trap_valid) begin
            new_src    = SRC_TRAP;
            new_target = trap_target;
        end else if (ex_valid) begin
            new_src    = SRC_EX;
            new_target = ex_target;
        end else if (id_valid) begin
            new_src    = SRC_ID;
            new_target = id_target;
        end
    end

    assign new_valid = trap_valid | ex_valid | id_valid;

    // Equal rank overwrites, so a younger EX redirect replaces an older pending EX.
    assign new_ge_pend = new_valid &
                         (~pend_valid | (src_rank(new_src) >= src_rank(pend_src)));

endmodule

// File: rtl/pc_gen_unit.sv
// rtl/pc_gen_unit.sv - registered next-PC generator for the IF stage
//
// Optional feature macro: PC_TRAP_REDIRECT_EN (adds trap_valid/trap_target, top priority).
//
// Ports:
//   clk, rstn          : clock, asynchronous active-low reset
//   stall_if           : hazard hold, PC must not advance
//   id_redir_valid/_target : ID-stage jump
//   ex_redir_valid/_target : EX-stage branch/jalr/mispredict redirect
//   trap_valid/_target : CSR trap/xret redirect (PC_TRAP_REDIRECT_EN only)
//   imem               : fetch request bus (imem_req_valid/ready, pc_if, pc_plus_if)
//   flush_if_id        : squash the IF/ID instruction (trap or EX redirect, not in BOOT)
//   misalign_err       : one-cycle pulse after an applied target had non-zero low bits
//   redir_cnt          : saturating count of applied redirects
module pc_gen_unit
    import pc_gen_pkg::*;
#(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              ILEN_B    = 4,
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             stall_if,
    input  logic             id_redir_valid,
    input  logic [XLEN-1:0]  id_redir_target,
    input  logic             ex_redir_valid,
    input  logic [XLEN-1:0]  ex_redir_target,
`ifdef PC_TRAP_REDIRECT_EN
    input  logic             trap_valid,
    input  logic [XLEN-1:0]  trap_target,
`endif
    pc_gen_unit_if.master    imem,
    output logic             flush_if_id,
    output logic             misalign_err,
    output logic [CNT_W-1:0] redir_cnt
);

    localparam int              ALIGN_W    = $clog2(ILEN_B);
    localparam logic [XLEN-1:0] STEP       = XLEN'(ILEN_B);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(ILEN_B - 1));
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic            pend_valid;
    pc_src_e         pend_src;
    logic [XLEN-1:0] pend_target;

    logic            trap_v;
    logic [XLEN-1:0] trap_t;
    logic            req_valid;
    logic            advance;

    pc_src_e         sel_src;
    logic [XLEN-1:0] sel_target;
    logic            new_valid;
    pc_src_e         new_src;
    logic [XLEN-1:0] new_target;
    logic            new_ge_pend;
    logic [XLEN-1:0] seq_target;

`ifdef PC_TRAP_REDIRECT_EN
    assign trap_v = trap_valid;
    assign trap_t = trap_target;
`else
    assign trap_v = 1'b0;
    assign trap_t = '0;
`endif

    // Wraps silently from the top of the address space to zero.
    assign seq_target = pc_q + STEP;

    pc_redirect_arb #(
        .XLEN(XLEN)
    ) u_arb (
        .trap_valid  (trap_v),
        .trap_target (trap_t),
        .ex_valid    (ex_redir_valid),
        .ex_target   (ex_redir_target),
        .pend_valid  (pend_valid),
        .pend_src    (pend_src),
        .pend_target (pend_target),
        .id_valid    (id_redir_valid),
        .id_target   (id_redir_target),
        .seq_target  (seq_target),
        .sel_src     (sel_src),
        .sel_target  (sel_target),
        .new_valid   (new_valid),
        .new_src     (new_src),
        .new_target  (new_target),
        .new_ge_pend (new_ge_pend)
    );

    assign advance = (state_q != BOOT) & req_valid & imem.imem_req_ready & ~stall_if;

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state. PEND is entered whenever a redirect has to wait for fetch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = (pend_valid | new_valid) ? PEND : RUN;
            RUN:     if (!advance && new_valid) state_d = PEND;
            PEND:    if (advance) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // FSM outputs. BOOT spends one cycle without a request so imem sees a clean PC.
    always_comb begin
        req_valid   = 1'b0;
        flush_if_id = 1'b0;
        case (state_q)
            RUN, PEND: begin
                req_valid   = 1'b1;
                flush_if_id = trap_v | ex_redir_valid;
            end
            default: begin
                req_valid   = 1'b0;
                flush_if_id = 1'b0;
            end
        endcase
    end

    assign imem.imem_req_valid = req_valid;
    assign imem.pc_if          = pc_q;
    assign imem.pc_plus_if     = seq_target;

    // PC register, pending slot, redirect counter and misalign pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q         <= RESET_VEC;
            pend_valid   <= 1'b0;
            pend_src     <= SRC_SEQ;
            pend_target  <= '0;
            redir_cnt    <= '0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            if (advance) begin
                pc_q       <= sel_target & ALIGN_MASK;
                // Any advance out of PEND consumes or supersedes the slot.
                pend_valid <= 1'b0;
                if (sel_src != SRC_SEQ) begin
                    if (redir_cnt != CNT_MAX) begin
                        redir_cnt <= redir_cnt + CNT_ONE;
                    end
                    misalign_err <= |sel_target[ALIGN_W-1:0];
                end
            end else if (new_ge_pend) begin
                pend_valid  <= 1'b1;
                pend_src    <= new_src;
                pend_target <= new_target;
            end
        end
    end

endmodule

// File: tb/tb_pc_gen_unit.sv
// tb/tb_pc_gen_unit.sv - self-checking bench for pc_gen_unit with a cycle-level reference model
module tb_pc_gen_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        stall_if;
    logic        id_redir_valid;
    logic [63:0] id_redir_target;
    logic        ex_redir_valid;
    logic [63:0] ex_redir_target;
`ifdef PC_TRAP_REDIRECT_EN
    logic        trap_valid;
    logic [63:0] trap_target;
`endif
    logic        flush_if_id;
    logic        misalign_err;
    logic [15:0] redir_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: fetch PC, one pending redirect (rank 1=id, 2=ex, 3=trap), counters.
    bit          m_boot;
    logic [63:0] m_pc;
    bit          m_pv;
    int          m_prank;
    logic [63:0] m_ptgt;
    int          m_cnt;
    bit          m_mis;
    bit          exp_valid, exp_flush;
    logic        obs_valid, obs_flush;

    always #5 clk = ~clk;

    pc_gen_unit_if #(.XLEN(64)) bus ();

    pc_gen_unit #(
        .XLEN      (64),
        .RESET_VEC (64'h1000),
        .ILEN_B    (4),
        .CNT_W     (16)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .stall_if        (stall_if),
        .id_redir_valid  (id_redir_valid),
        .id_redir_target (id_redir_target),
        .ex_redir_valid  (ex_redir_valid),
        .ex_redir_target (ex_redir_target),
`ifdef PC_TRAP_REDIRECT_EN
        .trap_valid      (trap_valid),
        .trap_target     (trap_target),
`endif
        .imem            (bus),
        .flush_if_id     (flush_if_id),
        .misalign_err    (misalign_err),
        .redir_cnt       (redir_cnt)
    );

    task automatic model_reset();
        m_boot = 1; m_pc = 64'h1000; m_pv = 0; m_prank = 0; m_ptgt = '0; m_cnt = 0; m_mis = 0;
    endtask

    task automatic model_step(input bit st, input bit rdy, input bit idv, input logic [63:0] idt,
                              input bit exv, input logic [63:0] ext, input bit trv, input logic [63:0] trt);
        logic [63:0] tgt;
        bit          redir;
        int          rank;
        exp_valid = !m_boot;
        exp_flush = (trv || exv) && !m_boot;
        m_mis = 0;
        if (exp_valid && rdy && !st) begin
            redir = 1;
            if (trv)       tgt = trt;
            else if (exv)  tgt = ext;
            else if (m_pv) tgt = m_ptgt;
            else if (idv)  tgt = idt;
            else begin redir = 0; tgt = m_pc + 64'd4; end
            if (redir) begin
                m_mis = (tgt[1:0] != 2'b00);
                m_pc  = {tgt[63:2], 2'b00};
                if (m_cnt < 65535) m_cnt++;
            end else begin
                m_pc = tgt;
            end
            m_pv = 0;
        end else begin
            rank = trv ? 3 : (exv ? 2 : (idv ? 1 : 0));
            tgt  = trv ? trt : (exv ? ext : idt);
            if (rank > 0 && (!m_pv || rank >= m_prank)) begin
                m_pv = 1; m_prank = rank; m_ptgt = tgt;
            end
        end
        m_boot = 0;
    endtask

    // One clock: drive at negedge, capture combinational outputs, step model, sample after posedge.
    task automatic tick(input bit st, input bit rdy, input bit idv, input logic [63:0] idt,
                        input bit exv, input logic [63:0] ext, input bit trv, input logic [63:0] trt);
        bit tv;
        tv = trv;
`ifndef PC_TRAP_REDIRECT_EN
        tv = 0;
`endif
        @(negedge clk);
        stall_if = st; bus.imem_req_ready = rdy;
        id_redir_valid = idv; id_redir_target = idt;
        ex_redir_valid = exv; ex_redir_target = ext;
`ifdef PC_TRAP_REDIRECT_EN
        trap_valid = tv; trap_target = trt;
`endif
        #1;
        obs_valid = bus.imem_req_valid;
        obs_flush = flush_if_id;
        model_step(st, rdy, idv, idt, exv, ext, tv, trt);
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        stall_if = 0; bus.imem_req_ready = 1;
        id_redir_valid = 0; id_redir_target = '0;
        ex_redir_valid = 0; ex_redir_target = '0;
`ifdef PC_TRAP_REDIRECT_EN
        trap_valid = 0; trap_target = '0;
`endif
    endtask

    // Reset and pass the BOOT cycle; afterwards pc_if = 'h1000 in RUN.
    task automatic do_reset();
        @(negedge clk);
        rstn = 0;
        drive_idle();
        model_reset();
        @(posedge clk); #1;
        rstn = 1;
        tick(0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rstn = 0;
        drive_idle();
        ex_redir_valid = 1; ex_redir_target = 64'h9000;
        model_reset();
        @(posedge clk); #1;
        n_checks++; if (bus.pc_if !== 64'h1000) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", bus.pc_if, 64'h1000); end
        n_checks++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.imem_req_valid); end
        n_checks++; if (flush_if_id !== 1'b0) begin n_fail++; $display("FAIL reset_flush got=%b exp=0", flush_if_id); end
        n_checks++; if (redir_cnt !== 16'h0 || misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_mis got=%h/%b exp=0/0", redir_cnt, misalign_err); end
        ex_redir_valid = 0;
        rstn = 1;
        tick(0, 1, 0, 0, 0, 0, 0, 0);
        n_checks++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL boot_valid got=%b exp=0", obs_valid); end
        n_checks++; if (bus.pc_if !== 64'h1000) begin n_fail++; $display("FAIL boot_pc0 got=%h exp=%h", bus.pc_if, 64'h1000); end
        for (int i = 1; i <= 2; i++) begin
            tick(0, 1, 0, 0, 0, 0, 0, 0);
            n_checks++; if (obs_valid !== 1'b1) begin n_fail++; $display("FAIL run_valid got=%b exp=1", obs_valid); end
            n_checks++; if (bus.pc_if !== 64'h1000 + 64'(4 * i)) begin n_fail++; $display("FAIL seq_pc got=%h exp=%h", bus.pc_if, 64'h1000 + 64'(4 * i)); end
        end
    endtask

    task automatic test_ex_redirect();
        do_reset();
        tick(0, 1, 0, 0, 1, 64'h2000, 0, 0);
        n_checks++; if (obs_flush !== 1'b1) begin n_fail++; $display("FAIL ex_flush got=%b exp=1", obs_flush); end
        n_checks++; if (bus.pc_if !== 64'h2000) begin n_fail++; $display("FAIL ex_pc got=%h exp=%h", bus.pc_if, 64'h2000); end
        n_checks++; if (redir_cnt !== 16'd1) begin n_fail++; $display("FAIL ex_cnt got=%0d exp=1", redir_cnt); end
        n_checks++; if (bus.pc_plus_if !== 64'h2004) begin n_fail++; $display("FAIL ex_pc_plus got=%h exp=%h", bus.pc_plus_if, 64'h2004); end
        tick(0, 1, 1, 64'h4000, 0, 0, 0, 0);
        n_checks++; if (obs_flush !== 1'b0) begin n_fail++; $display("FAIL id_noflush got=%b exp=0", obs_flush); end
        n_checks++; if (bus.pc_if !== 64'h4000 || redir_cnt !== 16'd2) begin n_fail++; $display("FAIL id_pc_cnt got=%h/%0d exp=4000/2", bus.pc_if, redir_cnt); end
    endtask

    task automatic test_stall_pending();
        do_reset();
        tick(1, 1, 0, 0, 1, 64'h3000, 0, 0);
        tick(1, 1, 0, 0, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 0, 0, 0, 0);
        n_checks++; if (bus.pc_if !== 64'h1000) begin n_fail++; $display("FAIL stall_hold got=%h exp=%h", bus.pc_if, 64'h1000); end
        n_checks++; if (redir_cnt !== 16'd0) begin n_fail++; $display("FAIL stall_cnt_latched got=%0d exp=0", redir_cnt); end
        tick(0, 1, 0, 0, 0, 0, 0, 0);
        n_checks++; if (bus.pc_if !== 64'h3000 || redir_cnt !== 16'd1) begin n_fail++; $display("FAIL stall_apply got=%h/%0d exp=3000/1", bus.pc_if, redir_cnt); end
        // Not-ready also blocks advance.
        tick(0, 0, 1, 64'h5000, 0, 0, 0, 0);
        n_checks++; if (bus.pc_if !== 64'h3000) begin n_fail++; $display("FAIL notready_hold got=%h exp=%h", bus.pc_if, 64'h3000); end
        tick(0, 1, 0, 0, 0, 0, 0, 0);
        n_checks++; if (bus.pc_if !== 64'h5000) begin n_fail++; $display("FAIL notready_apply got=%h exp=%h", bus.pc_if, 64'h5000); end
    endtask

    task automatic test_pend_priority();
        do_reset();
        tick(1, 1, 0, 0, 1, 64'h3000, 0, 0);
        tick(1, 1, 1, 64'h4000, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0, 0, 0);
        n_checks++; if (bus.pc_if !== 64'h3000) begin n_fail++; $display("FAIL id_no_overwrite got=%h exp=%h", bus.pc_if, 64'h3000); end
        tick(1, 1, 0, 0, 1, 64'h3000, 0, 0);
        tick(1, 1, 1, 64'h4000, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 1, 64'h5000, 0, 0);
        tick(0, 1, 0, 0, 0, 0, 0, 0);
        n_checks++; if (bus.pc_if !== 64'h5000 || redir_cnt !== 16'd2) begin n_fail++; $display("FAIL ex_overwrite got=%h/%0d exp=5000/2", bus.pc_if, redir_cnt); end
        // Pending wins over a same-cycle ID redirect.
        tick(1, 1, 1, 64'h6000, 0, 0, 0, 0);
        tick(0, 1, 1, 64'h7000, 0, 0, 0, 0);
        n_checks++; if (bus.pc_if !== 64'h6000) begin n_fail++; $display("FAIL pend_over_id got=%h exp=%h", bus.pc_if, 64'h6000); end
    endtask

    task automatic test_misalign_wrap();
        do_reset();
        tick(0, 1, 0, 0, 1, 64'h2002, 0, 0);
        n_checks++; if (bus.pc_if !== 64'h2000 || misalign_err !== 1'b1) begin n_fail++; $display("FAIL misalign_apply got=%h/%b exp=2000/1", bus.pc_if, misalign_err); end
        tick(0, 1, 0, 0, 0, 0, 0, 0);
        n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL misalign_pulse got=%b exp=0", misalign_err); end
        tick(1, 1, 0, 0, 1, 64'h3001, 0, 0);
        n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL misalign_latched got=%b exp=0", misalign_err); end
        tick(0, 1, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
        n_checks++; if (bus.pc_plus_if !== 64'h0) begin n_fail++; $display("FAIL wrap_plus got=%h exp=0", bus.pc_plus_if); end
        tick(0, 1, 0, 0, 0, 0, 0, 0);
        n_checks++; if (bus.pc_if !== 64'h0) begin n_fail++; $display("FAIL wrap_pc got=%h exp=0", bus.pc_if); end
    endtask

    task automatic test_boot_latch();
        @(negedge clk);
        rstn = 0;
        drive_idle();
        model_reset();
        @(posedge clk); #1;
        rstn = 1;
        tick(0, 1, 0, 0, 1, 64'h6000, 0, 0);
        n_checks++; if (obs_flush !== 1'b0) begin n_fail++; $display("FAIL boot_noflush got=%b exp=0", obs_flush); end
        n_checks++; if (bus.pc_if !== 64'h1000) begin n_fail++; $display("FAIL boot_hold got=%h exp=%h", bus.pc_if, 64'h1000); end
        tick(0, 1, 0, 0, 0, 0, 0, 0);
        n_checks++; if (bus.pc_if !== 64'h6000) begin n_fail++; $display("FAIL boot_pend_apply got=%h exp=%h", bus.pc_if, 64'h6000); end
    endtask

    task automatic test_reset_midop();
        do_reset();
        tick(1, 1, 0, 0, 1, 64'h7000, 0, 0);
        @(negedge clk);
        rstn = 0;
        drive_idle();
        #1;
        n_checks++; if (bus.pc_if !== 64'h1000 || bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset got=%h/%b exp=1000/0", bus.pc_if, bus.imem_req_valid); end
        model_reset();
        @(posedge clk); #1;
        rstn = 1;
        tick(0, 1, 0, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0, 0, 0);
        n_checks++; if (bus.pc_if !== 64'h1004) begin n_fail++; $display("FAIL pend_discard got=%h exp=%h", bus.pc_if, 64'h1004); end
    endtask

`ifdef PC_TRAP_REDIRECT_EN
    task automatic test_trap();
        do_reset();
        tick(0, 1, 0, 0, 1, 64'h2000, 1, 64'h8000);
        n_checks++; if (obs_flush !== 1'b1 || bus.pc_if !== 64'h8000) begin n_fail++; $display("FAIL trap_prio got=%b/%h exp=1/8000", obs_flush, bus.pc_if); end
    endtask
`endif

    task automatic test_random();
        logic [63:0] t1, t2, t3;
        bit          st, rdy, idv, exv, trv;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            t1 = {$urandom, $urandom}; t2 = {$urandom, $urandom}; t3 = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) begin t1[1:0] = 2'b00; t2[1:0] = 2'b00; end
            st  = ($urandom_range(0, 9) < 3);
            rdy = ($urandom_range(0, 9) < 8);
            idv = ($urandom_range(0, 9) < 2);
            exv = ($urandom_range(0, 19) < 3);
            trv = ($urandom_range(0, 19) == 0);
            tick(st, rdy, idv, t1, exv, t2, trv, t3);
            n_checks++; if (obs_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, obs_valid, exp_valid); end
            n_checks++; if (obs_flush !== exp_flush) begin n_fail++; $display("FAIL rnd_flush c=%0d got=%b exp=%b", c, obs_flush, exp_flush); end
            n_checks++; if (bus.pc_if !== m_pc) begin n_fail++; $display("FAIL rnd_pc c=%0d got=%h exp=%h", c, bus.pc_if, m_pc); end
            n_checks++; if (bus.pc_plus_if !== m_pc + 64'd4) begin n_fail++; $display("FAIL rnd_pc_plus c=%0d got=%h exp=%h", c, bus.pc_plus_if, m_pc + 64'd4); end
            n_checks++; if (misalign_err !== m_mis) begin n_fail++; $display("FAIL rnd_misalign c=%0d got=%b exp=%b", c, misalign_err, m_mis); end
            n_checks++; if (redir_cnt !== 16'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, redir_cnt, m_cnt); end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 1; i <= 65540; i++) begin
            tick(0, 1, 0, 0, 1, 64'h2000, 0, 0);
            if (i == 65534) begin
                n_checks++; if (redir_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_below got=%h exp=fffe", redir_cnt); end
            end
            if (i == 65535) begin
                n_checks++; if (redir_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach got=%h exp=ffff", redir_cnt); end
            end
        end
        n_checks++; if (redir_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got=%h exp=ffff", redir_cnt); end
    endtask

    initial begin
        rstn = 0;
        drive_idle();
        test_reset();
        test_ex_redirect();
        test_stall_pending();
        test_pend_priority();
        test_misalign_wrap();
        test_boot_latch();
        test_reset_midop();
`ifdef PC_TRAP_REDIRECT_EN
        test_trap();
`endif
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
